// File: rtl/instruction_fetch.sv
// Fetch stage: drives the PC into combinational instruction memory and registers the returned word.
// Optional FETCH_PERF_COUNTER_EN adds a saturating fetch_count output.
module instruction_fetch #(
    parameter int         PC_STEP     = 2,
    parameter logic [7:0] RESET_PC    = 8'h00,
    parameter logic [7:0] HALT_OPCODE = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stall,
    input  logic        branch_en,
    input  logic [7:0]  branch_target,
    input  logic [7:0]  instr_in,
    output logic [7:0]  pc_address,
    output logic [7:0]  instr_out,
    output logic [7:0]  instr_pc,
    output logic        instr_valid,
    output logic        halted
`ifdef FETCH_PERF_COUNTER_EN
    ,
    output logic [15:0] fetch_count
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [7:0] STEP = 8'(PC_STEP);

    state_t state_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            pc_address  <= RESET_PC;
            instr_out   <= 8'h00;
            instr_pc    <= 8'h00;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start)
                        state_reg <= RUN;
                end
                RUN: begin
                    // Stall outranks branch, so a branch raised during a stall waits for it to drop.
                    if (!stall) begin
                        if (branch_en) begin
                            pc_address  <= {branch_target[7:1], 1'b0};
                            instr_valid <= 1'b0;
                        end else if (instr_in == HALT_OPCODE) begin
                            instr_out   <= instr_in;
                            instr_pc    <= pc_address;
                            instr_valid <= 1'b1;
                            state_reg   <= HALT;
                        end else begin
                            instr_out   <= instr_in;
                            instr_pc    <= pc_address;
                            instr_valid <= 1'b1;
                            pc_address  <= pc_address + STEP;
                        end
                    end
                end
                HALT: begin
                    halted      <= 1'b1;
                    instr_valid <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef FETCH_PERF_COUNTER_EN
    logic capture;
    assign capture = (state_reg == RUN) && !stall && !branch_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            fetch_count <= 16'h0000;
        else if (capture && fetch_count != 16'hFFFF)
            fetch_count <= fetch_count + 16'h0001;
    end
`endif

endmodule
